// File: rtl/btb_fetch_pc_pkg.sv
// Shared constants and helpers for the fetch-stage next-PC generator and its BTB.
package btb_fetch_pc_pkg;

  localparam int          XLEN             = 32;
  localparam int          WORD_W           = XLEN - 2;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic int btb_index_w(input int size);
    return $clog2(size);
  endfunction

  function automatic int btb_tag_w(input int size);
    return WORD_W - $clog2(size);
  endfunction

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == {XLEN{1'b1}}) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/btb_fetch_pc_btb_array.sv
// Direct-mapped branch target buffer: async-reset valid bits, combinational read, clocked write.
module btb_fetch_pc_btb_array
  import btb_fetch_pc_pkg::*;
#(
  parameter int BTB_SIZE = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] rd_word,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [WORD_W-1:0] wr_target,
  output logic              hit,
  output logic [WORD_W-1:0] rd_target
);

  localparam int INDEX_W = btb_index_w(BTB_SIZE);
  localparam int TAG_W   = btb_tag_w(BTB_SIZE);

  logic [BTB_SIZE-1:0] valid;
  logic [TAG_W-1:0]    tag_mem [BTB_SIZE];
  logic [WORD_W-1:0]   tgt_mem [BTB_SIZE];

  logic [INDEX_W-1:0] rd_idx;
  logic [INDEX_W-1:0] wr_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic [TAG_W-1:0]   wr_tag;

  assign rd_idx = rd_word[INDEX_W-1:0];
  assign rd_tag = rd_word[WORD_W-1:INDEX_W];
  assign wr_idx = wr_word[INDEX_W-1:0];
  assign wr_tag = wr_word[WORD_W-1:INDEX_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tags and targets are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_target;
    end
  end

  assign hit       = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_target = tgt_mem[rd_idx];

endmodule

// File: rtl/btb_fetch_pc.sv
// Fetch-stage PC register, BTB-qualified prediction, EX mispredict redirect/flush and statistics.
module btb_fetch_pc
  import btb_fetch_pc_pkg::*;
#(
  parameter int          BTB_SIZE = 64,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stallF,
  input  logic        bhb_valid,
  input  logic        bhb_taken,
  output logic [31:0] pc_F,
  output logic [29:0] pc_word_F,
  output logic        pred_taken_F,
  output logic [31:0] pred_target_F,
  input  logic        branch_E,
  input  logic        taken_E,
  input  logic [31:0] pc_E,
  input  logic [31:0] target_E,
  input  logic        pred_taken_E,
  input  logic [31:0] pred_target_E,
  output logic        flush_DE,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  logic [31:0]       pc_q;
  logic [31:0]       branch_cnt_q;
  logic [31:0]       mispred_cnt_q;
  logic              btb_hit;
  logic [WORD_W-1:0] btb_target;
  logic [31:0]       target_aligned;
  logic [31:0]       correct_pc;
  logic              mispredict;
  logic              unused_target_lsb;

  // Fetch stage: prediction is formed in the same cycle as pc_F
  btb_fetch_pc_btb_array #(
    .BTB_SIZE(BTB_SIZE)
  ) u_btb (
    .clk      (clk),
    .rstn     (rstn),
    .rd_word  (pc_q[31:2]),
    .wr_en    (branch_E & taken_E),
    .wr_word  (pc_E[31:2]),
    .wr_target(target_E[31:2]),
    .hit      (btb_hit),
    .rd_target(btb_target)
  );

  assign pc_F          = pc_q;
  assign pc_word_F     = pc_q[31:2];
  assign pred_taken_F  = bhb_valid & bhb_taken & btb_hit;
  assign pred_target_F = pred_taken_F ? {btb_target, 2'b00} : pc_q + PC_STEP;

  // Execute stage: resolve against what fetch predicted for this instruction
  assign unused_target_lsb = ^target_E[1:0];
  assign target_aligned    = {target_E[31:2], 2'b00};
  assign mispredict = branch_E & ((taken_E != pred_taken_E) |
                                  (taken_E & pred_taken_E & (target_aligned != pred_target_E)));
  assign correct_pc = taken_E ? target_aligned : pc_E + PC_STEP;
  assign flush_DE   = mispredict;

  // A redirect must win over a stall, otherwise the wrong path would be held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else if (mispredict) begin
      pc_q <= correct_pc;
    end else if (!stallF) begin
      pc_q <= pred_target_F;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (branch_E)   branch_cnt_q  <= sat_inc(branch_cnt_q);
      if (mispredict) mispred_cnt_q <= sat_inc(mispred_cnt_q);
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_btb_fetch_pc.sv
// Directed-vector bench for btb_fetch_pc with hand-computed PCs, predictions and counters.
module tb_btb_fetch_pc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stallF;
  logic        bhb_valid;
  logic        bhb_taken;
  logic [31:0] pc_F;
  logic [29:0] pc_word_F;
  logic        pred_taken_F;
  logic [31:0] pred_target_F;
  logic        branch_E;
  logic        taken_E;
  logic [31:0] pc_E;
  logic [31:0] target_E;
  logic        pred_taken_E;
  logic [31:0] pred_target_E;
  logic        flush_DE;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mp = 0;

  btb_fetch_pc #(.BTB_SIZE(64), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stallF       (stallF),
    .bhb_valid    (bhb_valid),
    .bhb_taken    (bhb_taken),
    .pc_F         (pc_F),
    .pc_word_F    (pc_word_F),
    .pred_taken_F (pred_taken_F),
    .pred_target_F(pred_target_F),
    .branch_E     (branch_E),
    .taken_E      (taken_E),
    .pc_E         (pc_E),
    .target_E     (target_E),
    .pred_taken_E (pred_taken_E),
    .pred_target_E(pred_target_E),
    .flush_DE     (flush_DE),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One EX-stage branch cycle: drive at negedge, check flush, then PC and counters after the edge.
  task automatic do_branch(input string tag, input logic [31:0] pe, input logic [31:0] te,
                           input logic tk, input logic ptk, input logic [31:0] pte,
                           input logic stall, input logic exp_flush, input logic [31:0] exp_pc,
                           input logic chk_ptgt, input logic [31:0] exp_ptgt);
    @(negedge clk);
    branch_E = 1'b1; pc_E = pe; target_E = te; taken_E = tk;
    pred_taken_E = ptk; pred_target_E = pte; stallF = stall;
    #1;
    check({tag, ".flush"}, {31'd0, flush_DE}, {31'd0, exp_flush});
    if (chk_ptgt) check({tag, ".ptgt"}, pred_target_F, exp_ptgt);
    if (exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 1;
    if (exp_flush && exp_mp != 32'hFFFF_FFFF) exp_mp = exp_mp + 1;
    @(posedge clk);
    #1;
    check({tag, ".pc"}, pc_F, exp_pc);
    check({tag, ".bcnt"}, branch_cnt, exp_br);
    check({tag, ".mcnt"}, mispred_cnt, exp_mp);
    branch_E = 1'b0;
  endtask

  task automatic tick_check_pc(input string tag, input logic [31:0] exp_pc);
    @(posedge clk);
    #1;
    check(tag, pc_F, exp_pc);
  endtask

  initial begin
    rstn = 1'b0; stallF = 1'b0; bhb_valid = 1'b0; bhb_taken = 1'b0;
    branch_E = 1'b0; taken_E = 1'b0; pc_E = 0; target_E = 0;
    pred_taken_E = 1'b0; pred_target_E = 0;
    #12;
    check("rst.pc", pc_F, 32'h0);
    check("rst.ptaken", {31'd0, pred_taken_F}, 32'd0);
    check("rst.ptgt", pred_target_F, 32'h4);
    check("rst.flush", {31'd0, flush_DE}, 32'd0);
    check("rst.bcnt", branch_cnt, 32'd0);
    check("rst.mcnt", mispred_cnt, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick_check_pc("seq.pc4", 32'h4);
    tick_check_pc("seq.pc8", 32'h8);
    check("seq.word", {2'b00, pc_word_F}, 32'h2);

    // Cold taken branch: BTB miss was predicted not-taken
    do_branch("cold", 32'h10, 32'h80, 1'b1, 1'b0, 32'h14, 1'b0, 1'b1, 32'h80, 1'b0, 0);
    // Not-taken but predicted taken: redirect to pc_E+4 = 0x10
    do_branch("nt2", 32'hC, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h10, 1'b0, 0);

    @(negedge clk);
    stallF = 1'b1; bhb_valid = 1'b1; bhb_taken = 1'b1;
    #1;
    check("warm.ptaken", {31'd0, pred_taken_F}, 32'd1);
    check("warm.ptgt", pred_target_F, 32'h80);
    bhb_taken = 1'b0;
    #1;
    check("nt.ptaken", {31'd0, pred_taken_F}, 32'd0);
    check("nt.ptgt", pred_target_F, 32'h14);
    bhb_valid = 1'b0; bhb_taken = 1'b1;
    #1;
    check("nobhb.ptaken", {31'd0, pred_taken_F}, 32'd0);
    bhb_valid = 1'b1;

    // Wrong target; same-cycle read still returns the old 0x80
    do_branch("wtgt", 32'h10, 32'h90, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h90, 1'b1, 32'h80);
    do_branch("back", 32'hC, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h10, 1'b0, 0);
    #1;
    check("retgt.ptaken", {31'd0, pred_taken_F}, 32'd1);
    check("retgt.ptgt", pred_target_F, 32'h90);

    // Correctly predicted taken, stalled: no flush, PC held
    do_branch("okpred", 32'h10, 32'h90, 1'b1, 1'b1, 32'h90, 1'b1, 1'b0, 32'h10, 1'b1, 32'h90);
    // Redirect overrides stall
    do_branch("stlred", 32'h20, 32'h0, 1'b0, 1'b1, 32'h50, 1'b1, 1'b1, 32'h24, 1'b0, 0);
    // Correct not-taken under stall
    do_branch("oknt", 32'h30, 32'h0, 1'b0, 1'b0, 32'h34, 1'b1, 1'b0, 32'h24, 1'b0, 0);
    tick_check_pc("stall.hold", 32'h24);
    @(negedge clk);
    stallF = 1'b0; bhb_valid = 1'b0;
    tick_check_pc("unstall", 32'h28);

    // Alias: 0x110 shares index with 0x10 but differs in tag
    do_branch("alias", 32'h10C, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h110, 1'b0, 0);
    @(negedge clk);
    stallF = 1'b1; bhb_valid = 1'b1; bhb_taken = 1'b1;
    #1;
    check("alias.ptaken", {31'd0, pred_taken_F}, 32'd0);
    check("alias.ptgt", pred_target_F, 32'h114);
    check("alias.word", {2'b00, pc_word_F}, 32'h44);

    // Saturation: preload both counters with all-ones, then count another mispredict
    @(negedge clk);
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    exp_br = 32'hFFFF_FFFF;
    exp_mp = 32'hFFFF_FFFF;
    do_branch("sat", 32'h10C, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h110, 1'b0, 0);

    // Reset mid-run discards PC, counters and BTB valid bits
    @(negedge clk);
    rstn = 1'b0; stallF = 1'b0;
    #1;
    check("mrst.pc", pc_F, 32'h0);
    check("mrst.bcnt", branch_cnt, 32'd0);
    check("mrst.mcnt", mispred_cnt, 32'd0);
    check("mrst.ptgt", pred_target_F, 32'h4);
    @(negedge clk);
    rstn = 1'b1;
    tick_check_pc("mrst.pc4", 32'h4);
    tick_check_pc("mrst.pc8", 32'h8);
    tick_check_pc("mrst.pcc", 32'hC);
    tick_check_pc("mrst.pc10", 32'h10);
    check("mrst.btbclr", {31'd0, pred_taken_F}, 32'd0);
    check("mrst.ptgt10", pred_target_F, 32'h14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/btb_fetch_pc.md
Name: btb_fetch_pc

Overview:
Fetch-stage next-PC generator that consumes the branch history buffer's prediction (valid, taken) together with its own branch target buffer (BTB) of resolved targets. It owns the PC register and feeds PC word address to the history buffer every cycle. It also resolves EX-stage mispredictions into a redirect plus pipeline flush, and keeps branch/mispredict statistics.

Parameters:
BTB_SIZE, 64, number of BTB entries (power of two, >=2)
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
clk  input  1  system clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
stallF  input  1  hold PC (hazard unit)
bhb_valid  input  1  history buffer tag hit for current PC
bhb_taken  input  1  history buffer taken prediction for current PC
pc_F  output  32  current fetch PC
pc_word_F  output  30  pc_F[31:2], drives history buffer index/tag
pred_taken_F  output  1  final fetch prediction, carried down pipeline
pred_target_F  output  32  predicted next PC, carried down pipeline
branch_E  input  1  EX holds resolved branch or jal
taken_E  input  1  EX resolution: taken
pc_E  input  32  PC of EX instruction
target_E  input  32  computed branch target in EX
pred_taken_E  input  1  pred_taken_F of the EX instruction
pred_target_E  input  32  pred_target_F of the EX instruction
flush_DE  output  1  flush decode and execute (mispredict)
branch_cnt  output  32  resolved branch count, saturating
mispred_cnt  output  32  mispredict count, saturating

Behaviour:
- Reset (async, rstn=0): pc_F=RESET_PC, all BTB valid bits=0, branch_cnt=mispred_cnt=0; targets/tags not reset. Outputs derived combinationally therefore read pred_taken_F=0, pred_target_F=RESET_PC+4, flush_DE=0 (branch_E assumed low during reset). Reset mid-operation discards everything immediately.
- BTB entry: {valid, tag=pc[31:INDEX+2], target[31:2]}; INDEX=log2(BTB_SIZE); index=pc[INDEX+1:2]. Combinational read at pc_F.
- btb_hit = valid && tag match. pred_taken_F = bhb_valid & bhb_taken & btb_hit.
- pred_target_F = pred_taken_F ? {btb_target,2'b00} : pc_F+4 (32-bit wrap, no overflow flag).
- mispredict = branch_E & ((taken_E != pred_taken_E) | (taken_E & pred_taken_E & target_E != pred_target_E)).
- correct_pc = taken_E ? target_E : pc_E+4.
- flush_DE = mispredict, combinational, same cycle.
- Next PC priority: mispredict -> correct_pc (overrides stallF); else stallF -> hold; else pred_target_F. One-cycle redirect latency.
- BTB write at rising edge when branch_E & taken_E: entry[pc_E index] <= {1, tag, target_E[31:2]}. Not-taken branches leave BTB unchanged. Same-index read and write in one cycle: read returns old contents; new visible next cycle.
- target_E[1:0] ignored (treated as 0).
- branch_cnt +1 per cycle with branch_E; mispred_cnt +1 per mispredict; both hold at 32'hFFFF_FFFF.
- Latency: prediction zero-cycle (same cycle as pc_F); counters update one edge after event.

Decomposition:
- Shared package: XLEN=32, PC_STEP=4, RESET_PC default, BTB entry field widths derived from BTB_SIZE.
- One sub-module natural: btb_array (storage, async-reset valid bits, comb read port, sync write port, hit/target outputs). Next-PC mux, mispredict logic and counters stay in top.

Test Plan:
- Reset: assert rstn=0 mid-run with pc_F=0x40 -> pc_F=0x0 immediately, counters 0; release -> pc_F 0x4, 0x8 on successive edges.
- Cold taken branch: pc_E=0x10, target_E=0x80, taken_E=1, pred_taken_E=0 -> flush_DE=1 same cycle, pc_F=0x80 next edge, mispred_cnt=1, branch_cnt=1.
- Warm hit: pc_F=0x10, bhb_valid=1, bhb_taken=1 after above write -> pred_taken_F=1, pred_target_F=0x80; bhb_taken=0 -> pred_target_F=0x14.
- Wrong target: pred_taken_E=1, pred_target_E=0x80, taken_E=1, target_E=0x90 -> flush_DE=1, pc_F=0x90, BTB entry retargeted to 0x90.
- Stall vs redirect: stallF=1 with mispredict (taken_E=0, pred_taken_E=1, pc_E=0x20) -> pc_F=0x24; stallF=1 alone -> pc_F held.
- Aliasing/saturation: pc 0x10 and 0x10+4*BTB_SIZE -> second misses (tag); force counters to 0xFFFF_FFFF -> stay.
